// File: rtl/avg_frame_if.sv
// Stream-in / host-read bundle for avg_frame_reader.
// The master modport drives the upstream stream and the host strobes.
interface avg_frame_if #(
  parameter int unsigned DATA_W = 48,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned CNT_W  = 16
);
  logic [DATA_W-1:0] i_data;
  logic              i_data_valid;
  logic              o_data_ready;
  logic              i_rd_en;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              i_frame_ack;
  logic              o_frame_avail;
  logic [CNT_W-1:0]  o_frame_cnt;
  logic [ADDR_W-1:0] o_wr_index;

  modport master (
    output i_data, i_data_valid, i_rd_en, i_rd_addr, i_frame_ack,
    input  o_data_ready, o_rd_data, o_rd_valid, o_frame_avail, o_frame_cnt, o_wr_index
  );

  modport slave (
    input  i_data, i_data_valid, i_rd_en, i_rd_addr, i_frame_ack,
    output o_data_ready, o_rd_data, o_rd_valid, o_frame_avail, o_frame_cnt, o_wr_index
  );
endinterface

// File: rtl/avg_frame_reader.sv
// Ping-pong frame buffer for averaged FFT bins: fills one bank from the stream while
// the host reads and acknowledges the oldest completed bank.
module avg_frame_reader #(
  parameter int unsigned DATA_W    = 48,
  parameter int unsigned FRAME_LEN = 128,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned CNT_W     = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  avg_frame_if.slave   bus
);

  logic [DATA_W-1:0] r_mem [2*FRAME_LEN];

  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_wr_index;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [DATA_W-1:0] r_rd_raw;
  logic              r_rd_zero;
  logic              r_rd_valid;

  logic              w_ready;
  logic              w_avail;
  logic              w_accept;
  logic              w_last;
  logic              w_ack;
  logic [1:0]        w_full_d;

  assign w_ready  = ~r_full[r_wr_bank];
  assign w_avail  = r_full[r_rd_bank];
  assign w_accept = bus.i_data_valid & w_ready;
  assign w_last   = w_accept & (r_wr_index == ADDR_W'(FRAME_LEN - 1));
  assign w_ack    = bus.i_frame_ack & w_avail;

  // Completion targets the write bank (not full) and ack targets a full bank, so the
  // two updates never collide on the same flag.
  always_comb begin
    w_full_d = r_full;
    if (w_last) w_full_d[r_wr_bank] = 1'b1;
    if (w_ack)  w_full_d[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_index  <= '0;
      r_frame_cnt <= '0;
      r_rd_zero   <= 1'b1;
      r_rd_valid  <= 1'b0;
    end else begin
      r_full     <= w_full_d;
      r_rd_valid <= bus.i_rd_en;
      if (bus.i_rd_en) r_rd_zero <= ~w_avail;
      if (w_accept)    r_wr_index <= r_wr_index + 1'b1;
      if (w_last) begin
        r_wr_bank   <= ~r_wr_bank;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_ack) r_rd_bank <= ~r_rd_bank;
    end
  end

  // RAM ports kept reset-free so the buffer maps onto block RAM; the zero flag masks
  // the read register until a real read has landed.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_mem[{r_wr_bank, r_wr_index}] <= bus.i_data;
    if (bus.i_rd_en && w_avail) r_rd_raw <= r_mem[{r_rd_bank, bus.i_rd_addr}];
  end

  assign bus.o_data_ready  = w_ready;
  assign bus.o_frame_avail = w_avail;
  assign bus.o_frame_cnt   = r_frame_cnt;
  assign bus.o_wr_index    = r_wr_index;
  assign bus.o_rd_valid    = r_rd_valid;
  assign bus.o_rd_data     = r_rd_zero ? '0 : r_rd_raw;

endmodule

// File: tb/tb_avg_frame_reader.sv
// Self-checking bench for avg_frame_reader: read results go through a latency-1
// scoreboard queue; frame-level status is checked at fixed points.
module tb_avg_frame_reader;
  localparam int unsigned DATA_W    = 48;
  localparam int unsigned FRAME_LEN = 128;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned CNT_W     = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avg_frame_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  avg_frame_reader #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    int                phase;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
  } rd_vec_t;

  rd_vec_t           vecs[$];
  logic [DATA_W-1:0] sb_q[$];
  int                n_cmp = 0;
  int                n_err = 0;
  int                ready_low = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle and sample #1 after the edge; any read issued last cycle must
  // appear now.
  task automatic tick();
    logic [DATA_W-1:0] e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("rd_valid", 64'(bus.o_rd_valid), 64'd1);
      check("rd_data", 64'(bus.o_rd_data), 64'(e));
    end else begin
      check("rd_valid_idle", 64'(bus.o_rd_valid), 64'd0);
    end
  endtask

  task automatic send_bin(input logic [DATA_W-1:0] d);
    int g;
    g = 0;
    bus.i_data       = d;
    bus.i_data_valid = 1'b1;
    while (!bus.o_data_ready && g < 300) begin
      tick();
      ready_low++;
      g++;
    end
    if (g >= 300) check("ready_timeout", 64'(bus.o_data_ready), 64'd1);
    tick();
  endtask

  task automatic send_frame(input int base, input int mult, input bit gaps);
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      send_bin(DATA_W'(base + i * mult));
      if (gaps) begin
        bus.i_data_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    bus.i_data_valid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    bus.i_rd_en   = 1'b1;
    bus.i_rd_addr = a;
    sb_q.push_back(e);
    tick();
    bus.i_rd_en = 1'b0;
  endtask

  // Back-to-back reads of every table entry tagged with this phase.
  task automatic run_table(input int ph);
    foreach (vecs[k]) begin
      if (vecs[k].phase == ph) begin
        bus.i_rd_en   = 1'b1;
        bus.i_rd_addr = vecs[k].addr;
        sb_q.push_back(vecs[k].exp);
        tick();
      end
    end
    bus.i_rd_en = 1'b0;
  endtask

  initial begin
    vecs.push_back('{phase: 0, addr: 7'd5,   exp: 48'd15});
    vecs.push_back('{phase: 0, addr: 7'd0,   exp: 48'd0});
    vecs.push_back('{phase: 0, addr: 7'd64,  exp: 48'd192});
    vecs.push_back('{phase: 0, addr: 7'd127, exp: 48'd381});
    vecs.push_back('{phase: 1, addr: 7'd0,   exp: 48'd2000});
    vecs.push_back('{phase: 1, addr: 7'd127, exp: 48'd2127});
    vecs.push_back('{phase: 2, addr: 7'd0,   exp: 48'd3000});
    vecs.push_back('{phase: 2, addr: 7'd127, exp: 48'h8000_0000_0001});
    vecs.push_back('{phase: 2, addr: 7'd64,  exp: 48'd3064});
    vecs.push_back('{phase: 3, addr: 7'd0,   exp: 48'd5000});
    vecs.push_back('{phase: 3, addr: 7'd60,  exp: 48'd5420});
    vecs.push_back('{phase: 3, addr: 7'd127, exp: 48'd5889});

    bus.i_data       = '0;
    bus.i_data_valid = 1'b0;
    bus.i_rd_en      = 1'b0;
    bus.i_rd_addr    = '0;
    bus.i_frame_ack  = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 64'(bus.o_data_ready), 64'd1);
    check("rst_avail", 64'(bus.o_frame_avail), 64'd0);
    check("rst_cnt", 64'(bus.o_frame_cnt), 64'd0);
    check("rst_wr_index", 64'(bus.o_wr_index), 64'd0);
    check("rst_rd_data", 64'(bus.o_rd_data), 64'd0);

    // Frame A: index*3, valid held high
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      if (i == int'(FRAME_LEN) - 1) check("avail_before_last", 64'(bus.o_frame_avail), 64'd0);
      send_bin(DATA_W'(i * 3));
    end
    bus.i_data_valid = 1'b0;
    check("a_ready_held", 64'(ready_low), 64'd0);
    check("a_avail", 64'(bus.o_frame_avail), 64'd1);
    check("a_cnt", 64'(bus.o_frame_cnt), 64'd1);
    check("a_wr_index", 64'(bus.o_wr_index), 64'd0);
    run_table(0);
    tick();
    check("rd_hold", 64'(bus.o_rd_data), 64'd381);

    // Release A, then read and ack with nothing available
    bus.i_frame_ack = 1'b1;
    tick();
    bus.i_frame_ack = 1'b0;
    check("ack_a_avail", 64'(bus.o_frame_avail), 64'd0);
    bus.i_frame_ack = 1'b1;
    do_read(7'd5, 48'd0);
    bus.i_frame_ack = 1'b0;
    check("empty_ack_avail", 64'(bus.o_frame_avail), 64'd0);
    check("empty_ack_cnt", 64'(bus.o_frame_cnt), 64'd1);
    check("empty_ack_wr_index", 64'(bus.o_wr_index), 64'd0);
    check("empty_ack_ready", 64'(bus.o_data_ready), 64'd1);

    // Frames B and C with no ack: both banks full
    send_frame(1000, 1, 1'b0);
    send_frame(2000, 1, 1'b0);
    check("full_ready", 64'(bus.o_data_ready), 64'd0);
    check("full_avail", 64'(bus.o_frame_avail), 64'd1);
    check("full_cnt", 64'(bus.o_frame_cnt), 64'd3);
    bus.i_data       = 48'd3000;
    bus.i_data_valid = 1'b1;
    repeat (3) tick();
    check("held_wr_index", 64'(bus.o_wr_index), 64'd0);
    do_read(7'd3, 48'd1003);
    bus.i_frame_ack = 1'b1;
    tick();
    bus.i_frame_ack = 1'b0;
    check("ack_ready", 64'(bus.o_data_ready), 64'd1);
    check("ack_not_yet_taken", 64'(bus.o_wr_index), 64'd0);
    tick();
    bus.i_data_valid = 1'b0;
    check("d0_taken", 64'(bus.o_wr_index), 64'd1);
    run_table(1);

    // Frame D bins 1..126 with gaps; last bin completes as C is acked, with a read
    // in the same cycle that must still see C
    for (int i = 1; i < int'(FRAME_LEN) - 1; i++) begin
      send_bin(DATA_W'(3000 + i));
      bus.i_data_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    check("d_last_ready", 64'(bus.o_data_ready), 64'd1);
    check("d_avail_before", 64'(bus.o_frame_avail), 64'd1);
    bus.i_data       = 48'h8000_0000_0001;
    bus.i_data_valid = 1'b1;
    bus.i_frame_ack  = 1'b1;
    do_read(7'd127, 48'd2127);
    bus.i_data_valid = 1'b0;
    bus.i_frame_ack  = 1'b0;
    check("swap_avail", 64'(bus.o_frame_avail), 64'd1);
    check("swap_cnt", 64'(bus.o_frame_cnt), 64'd4);
    check("swap_ready", 64'(bus.o_data_ready), 64'd1);
    run_table(2);

    // Frame E: async reset part-way through
    for (int i = 0; i < 60; i++) send_bin(DATA_W'(4000 + i));
    bus.i_data_valid = 1'b0;
    check("pre_rst_wr_index", 64'(bus.o_wr_index), 64'd60);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_avail", 64'(bus.o_frame_avail), 64'd0);
    check("arst_cnt", 64'(bus.o_frame_cnt), 64'd0);
    check("arst_wr_index", 64'(bus.o_wr_index), 64'd0);
    check("arst_rd_data", 64'(bus.o_rd_data), 64'd0);
    check("arst_ready", 64'(bus.o_data_ready), 64'd1);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_frame(5000, 7, 1'b0);
    check("f_cnt", 64'(bus.o_frame_cnt), 64'd1);
    check("f_avail", 64'(bus.o_frame_avail), 64'd1);
    run_table(3);
    tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
